// File: rtl/isa_dma_arbiter.sv
// ISA DMA arbiter: synchronises DRQ1/3/5/7, grants one armed channel by fixed priority,
// drives AEN / DACK#, requests one bus-engine cycle per grant and counts transfers to TC.
// Ports: clk, reset (async active-low), drq in; dack_n/aen/xfer_req/xfer_chan out;
//        xfer_ack in; cfg_we/cfg_chan/cfg_count in; armed/tc/tc_chan out. All outputs registered.
module isa_dma_arbiter #(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         drq,
    output logic [3:0]         dack_n,
    output logic               aen,
    output logic               xfer_req,
    output logic [1:0]         xfer_chan,
    input  logic               xfer_ack,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_chan,
    input  logic [COUNT_W-1:0] cfg_count,
    output logic [3:0]         armed,
    output logic               tc,
    output logic [1:0]         tc_chan
);

    typedef enum logic [1:0] {IDLE, SETTLE, GRANT, RELEASE} state_t;

    state_t             state, state_nx;
    logic [3:0]         sync_q [SYNC_STAGES];
    logic [3:0]         drq_s;
    logic [3:0]         eligible;
    logic [1:0]         win_chan;
    logic [COUNT_W-1:0] count [4];
    logic               ack_fire;
    logic               cur_zero;
    logic               aen_d;
    logic               req_d;
    logic [3:0]         dack_d;
    logic [1:0]         chan_d;

    // DRQ synchroniser chain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'h0;
        end else begin
            sync_q[0] <= drq;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign drq_s    = sync_q[SYNC_STAGES-1];
    assign eligible = drq_s & armed;
    assign ack_fire = (state == GRANT) && xfer_ack;
    assign cur_zero = (count[xfer_chan] == '0);

    // Fixed priority: bit0 (DRQ1) highest
    always_comb begin
        win_chan = 2'd0;
        if      (eligible[0]) win_chan = 2'd0;
        else if (eligible[1]) win_chan = 2'd1;
        else if (eligible[2]) win_chan = 2'd2;
        else if (eligible[3]) win_chan = 2'd3;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Pin outputs are decoded from the next state and registered, so every
    // pin changes on the same edge as the state it belongs to.
    always_comb begin
        state_nx = state;
        chan_d   = xfer_chan;
        aen_d    = 1'b0;
        req_d    = 1'b0;
        dack_d   = 4'hF;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_nx = SETTLE;
                    chan_d   = win_chan;
                end
            end
            SETTLE:  state_nx = GRANT;
            GRANT:   if (xfer_ack) state_nx = RELEASE;
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        aen_d = (state_nx != IDLE);
        if (state_nx == GRANT) begin
            req_d          = 1'b1;
            dack_d[chan_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dack_n    <= 4'hF;
            aen       <= 1'b0;
            xfer_req  <= 1'b0;
            xfer_chan <= 2'd0;
        end else begin
            dack_n    <= dack_d;
            aen       <= aen_d;
            xfer_req  <= req_d;
            xfer_chan <= chan_d;
        end
    end

    // Terminal count reported even when a cfg write overrides the same channel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tc      <= 1'b0;
            tc_chan <= 2'd0;
        end else begin
            tc <= ack_fire && cur_zero;
            if (ack_fire && cur_zero) tc_chan <= xfer_chan;
        end
    end

    // Per-channel counters and arm bits; a cfg write beats the transfer update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed <= 4'h0;
            for (int i = 0; i < 4; i++) count[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cfg_we && (cfg_chan == 2'(i))) begin
                    count[i] <= cfg_count;
                    armed[i] <= 1'b1;
                end else if (ack_fire && (xfer_chan == 2'(i))) begin
                    count[i] <= count[i] - 1'b1;
                    if (cur_zero) armed[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_isa_dma_arbiter.sv
module tb_isa_dma_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  drq;
    logic [3:0]  dack_n;
    logic        aen;
    logic        xfer_req;
    logic [1:0]  xfer_chan;
    logic        xfer_ack;
    logic        cfg_we;
    logic [1:0]  cfg_chan;
    logic [15:0] cfg_count;
    logic [3:0]  armed;
    logic        tc;
    logic [1:0]  tc_chan;

    int total = 0;
    int bad   = 0;

    isa_dma_arbiter #(.SYNC_STAGES(2), .COUNT_W(16)) dut (
        .clk(clk), .reset(reset), .drq(drq), .dack_n(dack_n), .aen(aen),
        .xfer_req(xfer_req), .xfer_chan(xfer_chan), .xfer_ack(xfer_ack),
        .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_count(cfg_count),
        .armed(armed), .tc(tc), .tc_chan(tc_chan)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [15:0] cnt);
        cfg_we = 1'b1; cfg_chan = ch; cfg_count = cnt;
        step();
        cfg_we = 1'b0;
    endtask

    // Wait for a grant (bounded), capture it, ack once, then step through RELEASE.
    task automatic do_grant(output logic [1:0] ch, output logic [3:0] dk,
                            output logic got_tc, output logic [1:0] tcc,
                            output logic timeout);
        timeout = 1'b1; ch = 2'd0; dk = 4'hF; got_tc = 1'b0; tcc = 2'd0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (xfer_req) begin timeout = 1'b0; break; end
        end
        if (!timeout) begin
            ch = xfer_chan; dk = dack_n;
            xfer_ack = 1'b1;
            step();
            xfer_ack = 1'b0;
            got_tc = tc; tcc = tc_chan;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; drq = 4'h0; xfer_ack = 1'b0;
        cfg_we = 1'b0; cfg_chan = 2'd0; cfg_count = 16'h0;
        step(); step();
        reset = 1'b1;
        step();
        total++;
        if ({dack_n, aen, xfer_req, tc, xfer_chan, tc_chan, armed} !== {4'hF, 3'b000, 2'd0, 2'd0, 4'h0}) begin
            bad++;
            $display("FAIL reset_outputs: got dack_n=%b aen=%b req=%b tc=%b chan=%0d tcc=%0d armed=%b want dack_n=1111 rest 0",
                     dack_n, aen, xfer_req, tc, xfer_chan, tc_chan, armed);
        end
    endtask

    task automatic test_single_tc();
        int hits;
        cfg(2'd0, 16'd0);
        total++; if (armed !== 4'b0001) begin bad++; $display("FAIL t1_armed: got %b want 0001", armed); end
        drq = 4'b0001;
        step(); step();
        total++; if (aen !== 1'b0) begin bad++; $display("FAIL t1_aen_e2: got %b want 0", aen); end
        step();
        total++; if ({aen, dack_n, xfer_req} !== {1'b1, 4'hF, 1'b0}) begin
            bad++; $display("FAIL t1_settle: got aen=%b dack_n=%b req=%b want 1 1111 0", aen, dack_n, xfer_req); end
        step();
        total++; if ({dack_n, xfer_req, xfer_chan} !== {4'b1110, 1'b1, 2'd0}) begin
            bad++; $display("FAIL t1_grant: got dack_n=%b req=%b chan=%0d want 1110 1 0", dack_n, xfer_req, xfer_chan); end
        step();
        xfer_ack = 1'b1;
        step();
        xfer_ack = 1'b0;
        total++; if ({tc, tc_chan, armed, dack_n, aen, xfer_req} !== {1'b1, 2'd0, 4'h0, 4'hF, 1'b1, 1'b0}) begin
            bad++; $display("FAIL t1_ack: got tc=%b tcc=%0d armed=%b dack_n=%b aen=%b req=%b want 1 0 0000 1111 1 0",
                            tc, tc_chan, armed, dack_n, aen, xfer_req); end
        step();
        total++; if ({aen, tc} !== 2'b00) begin bad++; $display("FAIL t1_release: got aen=%b tc=%b want 0 0", aen, tc); end
        hits = 0;
        for (int i = 0; i < 8; i++) begin step(); if (aen) hits++; end
        total++; if (hits !== 0) begin bad++; $display("FAIL t1_no_regrant: got %0d aen cycles want 0", hits); end
    endtask

    task automatic test_multi_count();
        logic [1:0] ch, tcc; logic [3:0] dk; logic gt, to;
        drq = 4'b0010;
        cfg(2'd1, 16'd2);
        for (int k = 0; k < 3; k++) begin
            do_grant(ch, dk, gt, tcc, to);
            total++;
            if ({to, ch, dk, gt} !== {1'b0, 2'd1, 4'b1101, (k == 2)}) begin
                bad++; $display("FAIL t2_grant%0d: got to=%b ch=%0d dack=%b tc=%b want 0 1 1101 %0d", k, to, ch, dk, gt, (k == 2));
            end
            if (k == 0) begin
                total++; if (aen !== 1'b0) begin bad++; $display("FAIL t2_aen_gap: got %b want 0", aen); end
                step();
                total++; if ({aen, xfer_req} !== 2'b10) begin
                    bad++; $display("FAIL t2_b2b_aen: got aen=%b req=%b want 1 0", aen, xfer_req); end
            end
        end
        total++; if (dut.count[1] !== 16'hFFFF) begin bad++; $display("FAIL t2_count_wrap: got %h want ffff", dut.count[1]); end
        total++; if (armed !== 4'h0) begin bad++; $display("FAIL t2_armed: got %b want 0000", armed); end
        do_grant(ch, dk, gt, tcc, to);
        total++; if (to !== 1'b1) begin bad++; $display("FAIL t2_fourth_grant: got ch=%0d want no grant", ch); end
    endtask

    task automatic test_priority();
        logic [1:0] ch, tcc; logic [3:0] dk; logic gt, to;
        logic found;
        drq = 4'h0;
        step(); step(); step();
        cfg(2'd0, 16'd1); cfg(2'd1, 16'd1); cfg(2'd2, 16'd3); cfg(2'd3, 16'd3);
        drq = 4'b1110;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin step(); if (xfer_req) begin found = 1'b1; break; end end
        total++; if ({found, xfer_chan} !== {1'b1, 2'd1}) begin
            bad++; $display("FAIL t3_first: got found=%b chan=%0d want 1 1", found, xfer_chan); end
        drq = 4'b1111;
        step(); step();
        xfer_ack = 1'b1; step(); xfer_ack = 1'b0;
        total++; if (tc !== 1'b0) begin bad++; $display("FAIL t3_first_tc: got %b want 0", tc); end
        step();
        do_grant(ch, dk, gt, tcc, to);
        total++; if ({to, ch, dk, gt} !== {1'b0, 2'd0, 4'b1110, 1'b0}) begin
            bad++; $display("FAIL t3_ch0_a: got to=%b ch=%0d dack=%b tc=%b want 0 0 1110 0", to, ch, dk, gt); end
        do_grant(ch, dk, gt, tcc, to);
        total++; if ({to, ch, gt, tcc} !== {1'b0, 2'd0, 1'b1, 2'd0}) begin
            bad++; $display("FAIL t3_ch0_b: got to=%b ch=%0d tc=%b tcc=%0d want 0 0 1 0", to, ch, gt, tcc); end
        drq = 4'b0010;
        do_grant(ch, dk, gt, tcc, to);
        total++; if ({to, ch, dk, gt, tcc} !== {1'b0, 2'd1, 4'b1101, 1'b1, 2'd1}) begin
            bad++; $display("FAIL t3_ch1: got to=%b ch=%0d dack=%b tc=%b tcc=%0d want 0 1 1101 1 1", to, ch, dk, gt, tcc); end
        total++; if (armed !== 4'b1100) begin bad++; $display("FAIL t3_armed: got %b want 1100", armed); end
        drq = 4'h0;
        step(); step(); step();
    endtask

    task automatic test_drq_drop();
        logic found; int held;
        drq = 4'b0100;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin step(); if (xfer_req) begin found = 1'b1; break; end end
        total++; if ({found, xfer_chan, dack_n} !== {1'b1, 2'd2, 4'b1011}) begin
            bad++; $display("FAIL t4_grant: got found=%b chan=%0d dack=%b want 1 2 1011", found, xfer_chan, dack_n); end
        drq = 4'h0;
        held = 0;
        for (int i = 0; i < 3; i++) begin step(); if (xfer_req && dack_n == 4'b1011) held++; end
        total++; if (held !== 3) begin bad++; $display("FAIL t4_hold: got %0d held cycles want 3", held); end
        xfer_ack = 1'b1; step(); xfer_ack = 1'b0;
        total++; if ({tc, xfer_req, armed[2]} !== 3'b001 || dut.count[2] !== 16'd2) begin
            bad++; $display("FAIL t4_done: got tc=%b req=%b armed2=%b count=%0d want 0 0 1 2", tc, xfer_req, armed[2], dut.count[2]); end
        step(); step(); step(); step();
        total++; if (aen !== 1'b0) begin bad++; $display("FAIL t4_idle: got aen=%b want 0", aen); end
        xfer_ack = 1'b1; step(); xfer_ack = 1'b0;
        total++; if (tc !== 1'b0 || dut.count[2] !== 16'd2) begin
            bad++; $display("FAIL t4_stray_ack: got tc=%b count=%0d want 0 2", tc, dut.count[2]); end
    endtask

    task automatic test_cfg_vs_tc();
        logic found;
        cfg(2'd3, 16'd0);
        drq = 4'b1000;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin step(); if (xfer_req) begin found = 1'b1; break; end end
        total++; if ({found, xfer_chan} !== {1'b1, 2'd3}) begin
            bad++; $display("FAIL t5_grant: got found=%b chan=%0d want 1 3", found, xfer_chan); end
        drq = 4'h0;
        xfer_ack = 1'b1; cfg_we = 1'b1; cfg_chan = 2'd3; cfg_count = 16'd5;
        step();
        xfer_ack = 1'b0; cfg_we = 1'b0;
        total++; if ({tc, tc_chan, armed[3]} !== {1'b1, 2'd3, 1'b1} || dut.count[3] !== 16'd5) begin
            bad++; $display("FAIL t5_collide: got tc=%b tcc=%0d armed3=%b count=%0d want 1 3 1 5", tc, tc_chan, armed[3], dut.count[3]); end
        step(); step(); step(); step();
        total++; if (aen !== 1'b0) begin bad++; $display("FAIL t5_idle: got aen=%b want 0", aen); end
    endtask

    task automatic test_reset_mid_grant();
        logic found; int hits;
        drq = 4'b1000;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin step(); if (xfer_req) begin found = 1'b1; break; end end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL t6_grant: got found=%b want 1", found); end
        reset = 1'b0;
        #2;
        total++; if ({dack_n, aen, xfer_req, armed} !== {4'hF, 1'b0, 1'b0, 4'h0}) begin
            bad++; $display("FAIL t6_async: got dack_n=%b aen=%b req=%b armed=%b want 1111 0 0 0000", dack_n, aen, xfer_req, armed); end
        reset = 1'b1;
        hits = 0;
        for (int i = 0; i < 8; i++) begin step(); if (aen || xfer_req) hits++; end
        total++; if (hits !== 0 || armed !== 4'h0 || dut.count[3] !== 16'd0) begin
            bad++; $display("FAIL t6_after: got busy=%0d armed=%b count3=%0d want 0 0000 0", hits, armed, dut.count[3]); end
    endtask

    initial begin
        test_reset();
        test_single_tc();
        test_multi_count();
        test_priority();
        test_drq_drop();
        test_cfg_vs_tc();
        test_reset_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/isa_dma_arbiter.md
# isa_dma_arbiter

Drives the ISA DMA handshake on the riser. It synchronises the four DRQ lines (DRQ1/3/5/7), picks one armed channel by fixed priority, and drives AEN and the active-low DACK for that channel. It then asks the bus engine to run one transfer cycle and counts transfers per channel, raising terminal count at the end. It feeds the bus state machine's control input and the top-level DACK1/3/5/7 and AEN pins, all on the 8 MHz bus clock.

## Interface
- SYNC_STAGES, 2, flip-flop depth of the DRQ synchroniser (minimum 2)
- COUNT_W, 16, width of each per-channel transfer counter
- clk  in  1  bus clock (8 MHz PLL output); all logic on rising edge
- reset  in  1  asynchronous, active-low; one clock, no other clock domains
- drq  in  4  raw ISA DRQ lines, asynchronous; bit0=DRQ1, bit1=DRQ3, bit2=DRQ5, bit3=DRQ7
- dack_n  out  4  active-low DMA acknowledge, same bit order as drq; registered
- aen  out  1  address enable to ISA; high while a DMA grant is in progress; registered
- xfer_req  out  1  request to the bus engine for one DMA cycle
- xfer_chan  out  2  channel index for the current xfer_req
- xfer_ack  in  1  single-cycle pulse from the bus engine: the cycle has completed
- cfg_we  in  1  load the counter and arm the channel selected by cfg_chan
- cfg_chan  in  2  channel to configure
- cfg_count  in  COUNT_W  transfers minus one (8237 convention)
- armed  out  4  per-channel armed status
- tc  out  1  one-cycle terminal-count pulse
- tc_chan  out  2  channel that reached terminal count; valid with tc

## Operation
- Synchroniser: each drq bit passes through SYNC_STAGES flops, giving drq_s.
- Eligible channels: eligible = drq_s & armed. Priority is fixed; bit0 is highest and bit3 is lowest.
- FSM states: IDLE, SETTLE, GRANT, RELEASE.
- IDLE:
  - if eligible is nonzero, latch the winning channel into xfer_chan and go to SETTLE.
- SETTLE:
  - aen=1 for one cycle; all dack_n stay high so the address bus settles.
  - go to GRANT.
- GRANT:
  - aen=1, dack_n[xfer_chan]=0, xfer_req=1.
  - Stay in GRANT until xfer_ack is sampled high.
  - On ack: if count[xfer_chan]==0, pulse tc with tc_chan=xfer_chan, clear armed[xfer_chan], and let the count wrap to all-ones. Otherwise decrement the count.
  - Go to RELEASE.
- RELEASE:
  - dack_n all high, xfer_req=0, aen=1 for one cycle.
  - Go to IDLE. Arbitration restarts from IDLE, so every channel is single-transfer mode (one cycle per grant).
- Configuration:
  - cfg_we loads count[cfg_chan]=cfg_count and sets armed[cfg_chan]=1.
  - cfg_we is accepted in any state.
- Boundary rules:
  - cfg_we and a decrement (or tc) on the same channel in the same cycle: the cfg write wins, the channel stays armed, and tc is still pulsed.
  - drq falling during SETTLE or GRANT does not abort; the transfer completes.
  - xfer_ack outside GRANT is ignored.
  - A channel with armed=0 is never granted, whatever its drq level.
  - Re-arbitration happens only in IDLE. A higher-priority drq arriving mid-grant waits.
  - Reset asserted mid-grant: dack_n=4'hF, aen=0, xfer_req=0 immediately. Nothing is pending after release.

## Timing
- Reset values:
  - dack_n=4'hF; aen, xfer_req and tc are 0
  - xfer_chan=0, tc_chan=0
  - armed=0, all counts=0, synchroniser flops=0, state=IDLE
- All outputs come directly from flops; there are no combinational paths from inputs to outputs.
- With SYNC_STAGES=2, counting from the first edge that samples drq high:
  - drq_s is high after edge 2
  - aen rises after edge 3
  - dack_n low and xfer_req high after edge 4
- If xfer_ack is sampled at edge N:
  - dack_n high and xfer_req low after N; tc is high for the cycle after N
  - aen low after N+1
  - the next grant's aen can rise after N+2 at the earliest
- Minimum DACK low time is 1 cycle (xfer_ack in the first GRANT cycle).

## Test plan
- Reset, then arm ch0 with count 0 and hold drq=4'b0001: aen rises after edge 3 and dack_n=4'b1110 after edge 4. Ack after 2 cycles: tc=1 with tc_chan=0, armed=4'b0000, dack_n=4'hF, and no further grants.
- Arm ch1 with count 2 and hold drq[1] high with acks: exactly 3 grants, tc only on the third, and the count reads all-ones afterwards.
- Arm all channels and drive drq=4'b1110: ch1 is granted first. With drq=4'b1111 held high and acks given, grants stay on ch0 until its tc, then move to ch1 while ch0 drq stays high.
- Drop drq[2] in the first GRANT cycle: the grant holds until xfer_ack and the count decrements once.
- Issue cfg_we to ch3 with count 5 on the same edge as its terminal-count ack: tc pulses, armed[3] stays 1, and the count is 5.
- Assert reset in GRANT: dack_n=4'hF and aen=0 with no clock edge. After release, state is IDLE, armed=0, and drq produces no grant.
